// File: rtl/toy_itcm_req_ctrl_pkg.sv
// Shared widths for the ITCM fetch request/ack path.
package toy_pack;

    localparam int unsigned ADDR_WIDTH              = 32;
    localparam int unsigned FETCH_DATA_WIDTH        = 32;
    localparam int unsigned ICACHE_REQ_OPCODE_WIDTH = 2;
    localparam int unsigned MSHR_ENTRY_INDEX_WIDTH  = 2;
    localparam int unsigned ROB_ENTRY_ID_WIDTH      = 4;

    // Entry id carried alongside every ITCM request and returned with its ack.
    localparam int unsigned ITCM_ID_WIDTH = ICACHE_REQ_OPCODE_WIDTH
                                          + MSHR_ENTRY_INDEX_WIDTH
                                          + ROB_ENTRY_ID_WIDTH;

    // Width of a counter that must hold every value from 0 up to depth inclusive.
    function automatic int unsigned itcm_cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/toy_itcm_req_ctrl_ack_fifo.sv
// Registered in-order ack buffer with synchronous clear; no write-to-read bypass.
module toy_itcm_ack_fifo
    import toy_pack::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr_i,
    input  logic                      push_i,
    input  logic [WIDTH-1:0]          push_data_i,
    input  logic                      pop_i,
    output logic                      vld_o,
    output logic [WIDTH-1:0]          data_o,
    output logic [$clog2(DEPTH):0]    cnt_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = itcm_cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    // Next-state pointers and occupancy; clear wins over any push or pop.
    always_comb begin
        do_push  = push_i & (cnt_q != CNT_W'(DEPTH));
        do_pop   = pop_i & (cnt_q != '0);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (clr_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            // Pointers are PTR_W wide and DEPTH is a power of two, so they wrap on their own.
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is zeroed on reset so the head entry presents zero data afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push && !clr_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Head of the buffer is always presented; vld qualifies it.
    always_comb begin
        vld_o  = (cnt_q != '0);
        data_o = mem_q[rd_ptr_q];
        cnt_o  = cnt_q;
    end

endmodule

// File: rtl/toy_itcm_req_ctrl.sv
// Credit-limited ITCM fetch request controller with a buffered, flushable ack path.
module toy_itcm_req_ctrl
    import toy_pack::*;
#(
    parameter int unsigned ACK_DEPTH = 4,
    parameter int unsigned ID_W      = ICACHE_REQ_OPCODE_WIDTH + MSHR_ENTRY_INDEX_WIDTH
                                     + ROB_ENTRY_ID_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         up_req_vld,
    output logic                         up_req_rdy,
    input  logic [ADDR_WIDTH-1:0]        up_req_addr,
    input  logic [ID_W-1:0]              up_req_entry_id,
    output logic                         mem_req_vld,
    input  logic                         mem_req_rdy,
    output logic [ADDR_WIDTH-1:0]        mem_req_addr,
    output logic [ID_W-1:0]              mem_req_entry_id,
    input  logic                         mem_ack_vld,
    output logic                         mem_ack_rdy,
    input  logic [FETCH_DATA_WIDTH-1:0]  mem_ack_data,
    input  logic [ID_W-1:0]              mem_ack_entry_id,
    output logic                         dn_ack_vld,
    input  logic                         dn_ack_rdy,
    output logic [FETCH_DATA_WIDTH-1:0]  dn_ack_data,
    output logic [ID_W-1:0]              dn_ack_entry_id,
    input  logic                         flush,
    output logic [$clog2(ACK_DEPTH):0]   inflight_cnt,
    output logic                         err_unexp_ack
);

    localparam int unsigned CNT_W = itcm_cnt_width(ACK_DEPTH);
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam int unsigned ENT_W = ID_W + FETCH_DATA_WIDTH;

    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_vld;
    logic [ENT_W-1:0] fifo_wdata;
    logic [ENT_W-1:0] fifo_rdata;
    logic             fifo_push;
    logic             credit_ok;
    logic             req_fire;
    logic             ack_fire;
    logic             ack_unexp;
    logic             ack_counted;
    logic             ack_drop;

    // Request side: a slot is reserved for every issued request until its ack leaves the buffer.
    always_comb begin
        credit_ok        = (SUM_W'(inflight_q) + SUM_W'(fifo_cnt)) < SUM_W'(ACK_DEPTH);
        mem_req_vld      = up_req_vld & credit_ok & ~flush;
        up_req_rdy       = mem_req_rdy & credit_ok & ~flush;
        mem_req_addr     = up_req_addr;
        mem_req_entry_id = up_req_entry_id;
        req_fire         = mem_req_vld & mem_req_rdy;
    end

    // Ack classification: unexpected, dropped after a flush, or written to the buffer.
    always_comb begin
        mem_ack_rdy = 1'b1;
        ack_fire    = mem_ack_vld & mem_ack_rdy;
        ack_unexp   = ack_fire & (inflight_q == '0);
        ack_counted = ack_fire & ~ack_unexp;
        ack_drop    = ack_counted & (drop_q != '0);
        fifo_push   = ack_counted & ~ack_drop;
        fifo_wdata  = {mem_ack_entry_id, mem_ack_data};
    end

    // Counter next-state; flush blocks requests, so the reload equals the post-ack inflight count.
    always_comb begin
        case ({req_fire, ack_counted})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
        drop_d = drop_q;
        if (flush) begin
            drop_d = inflight_q - CNT_W'(ack_counted);
        end else if (ack_drop) begin
            drop_d = drop_q - CNT_W'(1);
        end
        err_d = err_q | ack_unexp;
    end

    // Counter and sticky error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= '0;
            drop_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            err_q      <= err_d;
        end
    end

    toy_itcm_ack_fifo #(
        .DEPTH (ACK_DEPTH),
        .WIDTH (ENT_W)
    ) u_ack_fifo (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (flush),
        .push_i      (fifo_push),
        .push_data_i (fifo_wdata),
        .pop_i       (dn_ack_rdy),
        .vld_o       (fifo_vld),
        .data_o      (fifo_rdata),
        .cnt_o       (fifo_cnt)
    );

    // Downstream ack and status outputs.
    always_comb begin
        dn_ack_vld                     = fifo_vld;
        {dn_ack_entry_id, dn_ack_data} = fifo_rdata;
        inflight_cnt                   = inflight_q;
        err_unexp_ack                  = err_q;
    end

endmodule

// File: tb/tb_toy_itcm_req_ctrl.sv
// Bench for toy_itcm_req_ctrl: table vectors, directed corner sequences, random traffic vs a queue model.
module tb_toy_itcm_req_ctrl;
    import toy_pack::*;

    localparam int ACK_DEPTH = 4;
    localparam int ID_W = ITCM_ID_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic up_req_vld = 1'b0;
    logic up_req_rdy;
    logic [ADDR_WIDTH-1:0] up_req_addr = '0;
    logic [ID_W-1:0] up_req_entry_id = '0;
    logic mem_req_vld;
    logic mem_req_rdy = 1'b0;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic [ID_W-1:0] mem_req_entry_id;
    logic mem_ack_vld = 1'b0;
    logic mem_ack_rdy;
    logic [FETCH_DATA_WIDTH-1:0] mem_ack_data = '0;
    logic [ID_W-1:0] mem_ack_entry_id = '0;
    logic dn_ack_vld;
    logic dn_ack_rdy = 1'b0;
    logic [FETCH_DATA_WIDTH-1:0] dn_ack_data;
    logic [ID_W-1:0] dn_ack_entry_id;
    logic flush = 1'b0;
    logic [$clog2(ACK_DEPTH):0] inflight_cnt;
    logic err_unexp_ack;

    always #5 clk = ~clk;

    toy_itcm_req_ctrl #(.ACK_DEPTH(ACK_DEPTH), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst),
        .up_req_vld(up_req_vld), .up_req_rdy(up_req_rdy),
        .up_req_addr(up_req_addr), .up_req_entry_id(up_req_entry_id),
        .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy),
        .mem_req_addr(mem_req_addr), .mem_req_entry_id(mem_req_entry_id),
        .mem_ack_vld(mem_ack_vld), .mem_ack_rdy(mem_ack_rdy),
        .mem_ack_data(mem_ack_data), .mem_ack_entry_id(mem_ack_entry_id),
        .dn_ack_vld(dn_ack_vld), .dn_ack_rdy(dn_ack_rdy),
        .dn_ack_data(dn_ack_data), .dn_ack_entry_id(dn_ack_entry_id),
        .flush(flush), .inflight_cnt(inflight_cnt), .err_unexp_ack(err_unexp_ack)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ITCM environment: fixed latency, one ack per due cycle.
    typedef struct { logic [ADDR_WIDTH-1:0] addr; logic [ID_W-1:0] id; int due; } itcm_t;
    typedef struct { logic [FETCH_DATA_WIDTH-1:0] data; logic [ID_W-1:0] id; } ack_t;

    itcm_t itcm_q[$];
    int    itcm_lat = 2;
    bit    itcm_en = 1;
    bit    inj_ack = 0;
    int    cyc = 0;

    function automatic logic [FETCH_DATA_WIDTH-1:0] itcm_data(input logic [ADDR_WIDTH-1:0] a,
                                                               input logic [ID_W-1:0] id);
        return {a[23:0], id} ^ 32'hC3C3_0000;
    endfunction

    // Reference model state.
    bit   model_en = 0;
    int   m_infl = 0;
    int   m_drop = 0;
    bit   m_err = 0;
    ack_t m_fifo[$];

    // Bookkeeping of observed traffic for directed sequences.
    logic [ID_W-1:0] delivered[$];
    int   issued = 0;
    bit   last_up_fire = 0;

    task automatic model_step();
        logic exp_credit, exp_mvld, exp_urdy, do_push;
        exp_credit = (m_infl + m_fifo.size()) < ACK_DEPTH;
        exp_mvld   = up_req_vld && exp_credit && !flush;
        exp_urdy   = mem_req_rdy && exp_credit && !flush;
        chk("mem_req_vld", mem_req_vld, exp_mvld);
        chk("up_req_rdy", up_req_rdy, exp_urdy);
        chk("mem_ack_rdy", mem_ack_rdy, 1'b1);
        chk("dn_ack_vld", dn_ack_vld, m_fifo.size() != 0);
        if (m_fifo.size() != 0) begin
            chk("dn_ack_data", dn_ack_data, m_fifo[0].data);
            chk("dn_ack_entry_id", dn_ack_entry_id, m_fifo[0].id);
        end
        if (exp_mvld) begin
            chk("mem_req_addr", mem_req_addr, up_req_addr);
            chk("mem_req_entry_id", mem_req_entry_id, up_req_entry_id);
        end
        chk("inflight_cnt", inflight_cnt, m_infl);
        chk("err_unexp_ack", err_unexp_ack, m_err);
        do_push = 0;
        if (mem_ack_vld) begin
            if (m_infl == 0) m_err = 1;
            else begin
                m_infl--;
                if (flush) ;
                else if (m_drop > 0) m_drop--;
                else do_push = 1;
            end
        end
        if (flush) begin
            m_fifo.delete();
            m_drop = m_infl;
        end else begin
            if (dn_ack_rdy && m_fifo.size() != 0) void'(m_fifo.pop_front());
            if (do_push) m_fifo.push_back('{mem_ack_data, mem_ack_entry_id});
        end
        if (exp_mvld && mem_req_rdy) m_infl++;
    endtask

    // One clock cycle: drive ITCM ack, settle, check/update model, advance past the edge.
    task automatic tick();
        logic req_fire, head_due;
        head_due = itcm_q.size() != 0 && itcm_q[0].due == cyc;
        if (itcm_en) begin
            mem_ack_vld = inj_ack || head_due;
            if (inj_ack) begin
                mem_ack_data = 32'hDEAD_BEEF;
                mem_ack_entry_id = 8'hEE;
            end else if (head_due) begin
                mem_ack_data = itcm_data(itcm_q[0].addr, itcm_q[0].id);
                mem_ack_entry_id = itcm_q[0].id;
            end else begin
                mem_ack_data = '0;
                mem_ack_entry_id = '0;
            end
        end
        #1;
        req_fire = mem_req_vld && mem_req_rdy;
        last_up_fire = up_req_vld && up_req_rdy;
        if (last_up_fire) issued++;
        if (dn_ack_vld && dn_ack_rdy) delivered.push_back(dn_ack_entry_id);
        if (model_en) model_step();
        if (itcm_en) begin
            if (head_due && !inj_ack) void'(itcm_q.pop_front());
            if (req_fire) itcm_q.push_back('{mem_req_addr, mem_req_entry_id, cyc + itcm_lat});
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1; up_req_vld = 0; flush = 0; mem_req_rdy = 0; dn_ack_rdy = 0; inj_ack = 0;
        itcm_q.delete();
        model_en = 0;
        tick();
        rst = 0;
        m_infl = 0; m_drop = 0; m_err = 0; m_fifo.delete();
        model_en = 1;
        chk("rst_inflight_cnt", inflight_cnt, 0);
        chk("rst_dn_ack_vld", dn_ack_vld, 0);
        chk("rst_dn_ack_data", dn_ack_data, 0);
        chk("rst_dn_ack_entry_id", dn_ack_entry_id, 0);
        chk("rst_err_unexp_ack", err_unexp_ack, 0);
    endtask

    task automatic single_req(input logic [ADDR_WIDTH-1:0] a, input logic [ID_W-1:0] id,
                              input string tag);
        int t0, got;
        got = -1;
        dn_ack_rdy = 1; mem_req_rdy = 1; flush = 0;
        up_req_vld = 1; up_req_addr = a; up_req_entry_id = id;
        t0 = cyc;
        tick();
        up_req_vld = 0;
        chk({tag, "_accept"}, last_up_fire, 1);
        for (int k = 0; k < 10; k++) begin
            if (dn_ack_vld && got < 0) begin
                got = cyc - t0;
                chk({tag, "_id"}, dn_ack_entry_id, id);
                chk({tag, "_data"}, dn_ack_data, itcm_data(a, id));
            end
            tick();
        end
        chk({tag, "_latency"}, got, 3);
        chk({tag, "_inflight_zero"}, inflight_cnt, 0);
    endtask

    typedef struct {
        logic up, mrdy, ack, dnr, fl;
        logic e_mvld, e_urdy, e_dvld;
        int   e_infl;
        logic e_err;
        logic [7:0] e_id;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int k, vld_seen, n_before;

        //            up mr ak dr fl | mv ur dv infl err id
        tbl[0]  = '{1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 8'd0};
        tbl[1]  = '{1, 1, 0, 0, 0,  1, 1, 0, 0, 0, 8'd0};
        tbl[2]  = '{1, 1, 0, 0, 0,  1, 1, 0, 1, 0, 8'd0};
        tbl[3]  = '{0, 1, 1, 0, 0,  0, 1, 0, 2, 0, 8'd0};
        tbl[4]  = '{1, 1, 0, 0, 0,  1, 1, 1, 1, 0, 8'd3};
        tbl[5]  = '{1, 1, 0, 0, 0,  1, 1, 1, 2, 0, 8'd3};
        tbl[6]  = '{1, 1, 0, 0, 0,  0, 0, 1, 3, 0, 8'd3};
        tbl[7]  = '{1, 1, 1, 0, 0,  0, 0, 1, 3, 0, 8'd3};
        tbl[8]  = '{1, 1, 0, 1, 0,  0, 0, 1, 2, 0, 8'd3};
        tbl[9]  = '{1, 1, 0, 0, 1,  0, 0, 1, 2, 0, 8'd7};
        tbl[10] = '{0, 1, 1, 0, 0,  0, 1, 0, 2, 0, 8'd0};
        tbl[11] = '{0, 1, 1, 0, 0,  0, 1, 0, 1, 0, 8'd0};
        tbl[12] = '{0, 1, 1, 0, 0,  0, 1, 0, 0, 0, 8'd0};
        tbl[13] = '{0, 1, 0, 0, 0,  0, 1, 0, 0, 1, 8'd0};

        @(posedge clk);
        #1;
        do_reset();

        // Table vectors: acks driven straight from the table.
        itcm_en = 0;
        model_en = 0;
        for (int i = 0; i < 14; i++) begin
            up_req_vld = tbl[i].up; up_req_addr = 32'h200 + i * 4; up_req_entry_id = 8'(i);
            mem_req_rdy = tbl[i].mrdy; mem_ack_vld = tbl[i].ack;
            mem_ack_data = 32'hD000_0000 + i; mem_ack_entry_id = 8'(i);
            dn_ack_rdy = tbl[i].dnr; flush = tbl[i].fl;
            #1;
            chk($sformatf("tbl%0d_mem_req_vld", i), mem_req_vld, tbl[i].e_mvld);
            chk($sformatf("tbl%0d_up_req_rdy", i), up_req_rdy, tbl[i].e_urdy);
            chk($sformatf("tbl%0d_dn_ack_vld", i), dn_ack_vld, tbl[i].e_dvld);
            chk($sformatf("tbl%0d_inflight", i), inflight_cnt, tbl[i].e_infl);
            chk($sformatf("tbl%0d_err", i), err_unexp_ack, tbl[i].e_err);
            if (tbl[i].e_dvld) begin
                chk($sformatf("tbl%0d_dn_id", i), dn_ack_entry_id, tbl[i].e_id);
                chk($sformatf("tbl%0d_dn_data", i), dn_ack_data, 32'hD000_0000 + tbl[i].e_id);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        mem_ack_vld = 0;
        itcm_en = 1;
        do_reset();

        // Single request end-to-end latency.
        single_req(32'h100, 8'd5, "single");

        // Backpressure: six requests with the buffer blocked.
        delivered.delete();
        dn_ack_rdy = 0; mem_req_rdy = 1; k = 0;
        for (int c = 0; c < 12; c++) begin
            up_req_vld = 1; up_req_addr = 32'h3000 + k * 4; up_req_entry_id = 8'(8'h10 + k);
            tick();
            if (last_up_fire) k++;
        end
        chk("bp_issued_before_release", k, 4);
        chk("bp_up_req_rdy_blocked", up_req_rdy, 0);
        dn_ack_rdy = 1;
        for (int c = 0; c < 40 && k < 6; c++) begin
            up_req_vld = 1; up_req_addr = 32'h3000 + k * 4; up_req_entry_id = 8'(8'h10 + k);
            tick();
            if (last_up_fire) k++;
        end
        up_req_vld = 0;
        chk("bp_issued_total", k, 6);
        repeat (10) tick();
        chk("bp_delivered_count", delivered.size(), 6);
        for (int j = 0; j < 6; j++)
            chk($sformatf("bp_order%0d", j),
                (j < delivered.size()) ? delivered[j] : 8'hFF, 8'h10 + j);

        // Concurrent request and ack every cycle.
        delivered.delete(); issued = 0;
        mem_req_rdy = 1; dn_ack_rdy = 1; up_req_vld = 1;
        for (int c = 0; c < 4; c++) begin
            up_req_addr = 32'h1000 + c * 4; up_req_entry_id = 8'(c); tick();
        end
        n_before = delivered.size();
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("steady_inflight%0d", c), inflight_cnt, 2);
            up_req_addr = 32'h1100 + c * 4; up_req_entry_id = 8'(8'h40 + c); tick();
        end
        chk("steady_delivered", delivered.size() - n_before, 10);
        up_req_vld = 0;
        repeat (6) tick();
        chk("steady_no_loss", delivered.size(), issued);

        // Flush with three in flight and one buffered.
        itcm_lat = 8; dn_ack_rdy = 0; mem_req_rdy = 1;
        up_req_vld = 1; up_req_addr = 32'h500; up_req_entry_id = 8'h50; tick();
        up_req_vld = 0; tick();
        for (int c = 1; c <= 3; c++) begin
            up_req_vld = 1; up_req_addr = 32'h500 + c * 4; up_req_entry_id = 8'(8'h50 + c); tick();
        end
        up_req_vld = 0;
        for (int c = 0; c < 20 && !dn_ack_vld; c++) tick();
        chk("flush_pre_buffered", dn_ack_vld, 1);
        chk("flush_pre_inflight", inflight_cnt, 3);
        flush = 1; tick(); flush = 0;
        chk("flush_fifo_empty", dn_ack_vld, 0);
        dn_ack_rdy = 1; vld_seen = 0;
        for (int c = 0; c < 15; c++) begin
            if (dn_ack_vld) vld_seen++;
            tick();
        end
        chk("flush_no_dn_ack", vld_seen, 0);
        chk("flush_inflight_zero", inflight_cnt, 0);
        chk("flush_credit_back", up_req_rdy, 1);
        itcm_lat = 2;

        // Unexpected ack with nothing in flight.
        inj_ack = 1; tick(); inj_ack = 0;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("unexp_sticky%0d", c), err_unexp_ack, 1);
            tick();
        end
        chk("unexp_inflight", inflight_cnt, 0);
        chk("unexp_no_dn_ack", dn_ack_vld, 0);

        // Reset with two requests in flight, then normal operation.
        mem_req_rdy = 1; dn_ack_rdy = 1;
        for (int c = 0; c < 2; c++) begin
            up_req_vld = 1; up_req_addr = 32'h700 + c * 4; up_req_entry_id = 8'(8'h70 + c); tick();
        end
        up_req_vld = 0;
        chk("midrst_inflight_before", inflight_cnt, 2);
        do_reset();
        single_req(32'h840, 8'h2A, "post_rst");

        // Randomised traffic at two ITCM latencies.
        for (int p = 0; p < 2; p++) begin
            itcm_lat = (p == 0) ? 2 : 5;
            for (int n = 0; n < 400; n++) begin
                up_req_vld = 1'($urandom_range(0, 1));
                up_req_addr = $urandom;
                up_req_entry_id = 8'($urandom);
                mem_req_rdy = ($urandom_range(0, 3) != 0);
                dn_ack_rdy = ($urandom_range(0, 2) != 0);
                flush = ($urandom_range(0, 31) == 0);
                tick();
            end
            flush = 0; up_req_vld = 0; dn_ack_rdy = 1;
            repeat (12) tick();
            chk($sformatf("rand%0d_drained_inflight", p), inflight_cnt, 0);
            chk($sformatf("rand%0d_drained_dn", p), dn_ack_vld, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
